// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared types and constants for the instruction memory boot loader
//
// Purpose: loader FSM state encoding, frame marker and field widths, default
//          geometry, and a helper that says whether a state is inside a frame.
// Ports:   none (package).
package imem_boot_loader_pkg;

  localparam int unsigned IMEM_DEPTH_DEF = 256;
  localparam int unsigned TIMEOUT_DEF    = 1024;
  localparam logic [7:0]  SYNC_BYTE      = 8'hA5;
  localparam int unsigned CHK_W          = 8;
  localparam int unsigned LEN_W          = 16;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_e;

  // States between the sync byte and the checksum byte; the inter-byte
  // timeout only runs here.
  function automatic logic in_frame(input loader_state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream in and instruction memory write port out
//
// Purpose: bundles the incoming byte handshake and the imem write port.
// Signals: rx_data/rx_valid/rx_ready  byte stream, transfer = rx_valid & rx_ready
//          imem_we/imem_addr/imem_wdata  one-cycle word write strobe
// Modports: master = byte source / memory side, slave = loader side.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
) ();
  import imem_boot_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader_assembler.sv
// rtl/imem_boot_loader_assembler.sv - packs bytes MSB-first into words and registers the imem write
//
// Purpose: byte lane counter, 24-bit shift register and registered write port.
// Ports:   clk, rst        clock, synchronous active-high reset
//          byte_en         accepted data byte this cycle
//          byte_data       the byte
//          word_done       combinational: this byte completes a word
//          imem_we/addr/wdata  registered write, one cycle after the 4th byte
//          word_count      words written since reset
module imem_boot_loader_assembler
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_done,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic [ADDR_W:0]   word_count
);

  logic [1:0]        lane_q, lane_d;
  logic [23:0]       shift_q, shift_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;

  always_comb begin
    lane_d    = lane_q;
    shift_d   = shift_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    count_d   = count_q;
    word_done = byte_en && (lane_q == 2'd3);
    if (byte_en) begin
      lane_d  = lane_q + 2'd1;
      shift_d = {shift_q[15:0], byte_data};
      if (lane_q == 2'd3) begin
        // The word index is the count before this word; the frame length
        // check upstream keeps it below the memory depth.
        we_d    = 1'b1;
        addr_d  = count_q[ADDR_W-1:0];
        wdata_d = {shift_q, byte_data};
        count_d = count_q + (ADDR_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q  <= 2'd0;
      shift_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = count_q;

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed byte-stream program loader for the instruction memory
//
// Purpose: parses SYNC, LEN_HI, LEN_LO, 4*N data bytes, CHK; writes words to
//          imem from address 0 and releases the core reset on a good frame.
// Ports:   clk, rst        clock, synchronous active-high reset
//          bus (slave)     rx byte stream in, imem write port out
//          core_rst_n      active-low core reset, released one cycle after DONE
//          load_done       sticky, frame accepted
//          load_err        sticky, frame rejected
//          word_count      words written in the current/last frame
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH),
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  imem_boot_loader_if.slave   bus,
  output logic                core_rst_n,
  output logic                load_done,
  output logic                load_err,
  output logic [ADDR_W:0]     word_count
);

  localparam int TO_W = $clog2(TIMEOUT);

  loader_state_e     state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [LEN_W:0]    len_q, len_d;
  logic [CHK_W-1:0]  chk_q, chk_d;
  logic [TO_W-1:0]   idle_q, idle_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              core_rst_n_q, core_rst_n_d;

  logic              rx_ready;
  logic              accept;
  logic              byte_en;
  logic              word_done;
  logic              frame_last;
  logic [LEN_W:0]    len_rx;

  assign accept  = bus.rx_valid && rx_ready;
  assign byte_en = accept && (state_q == ST_DATA);
  // Zero-extended to 17 bits so 65535 still compares correctly against the depth.
  assign len_rx  = {1'b0, len_hi_q, bus.rx_data};
  // The byte completing word N-1 ends the data phase.
  assign frame_last = word_done &&
                      (((LEN_W + 1)'(word_count) + (LEN_W + 1)'(1)) == len_q);

  imem_boot_loader_assembler #(
    .ADDR_W (ADDR_W)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_en    (byte_en),
    .byte_data  (bus.rx_data),
    .word_done  (word_done),
    .imem_we    (bus.imem_we),
    .imem_addr  (bus.imem_addr),
    .imem_wdata (bus.imem_wdata),
    .word_count (word_count)
  );

  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    len_d        = len_q;
    chk_d        = chk_q;
    idle_d       = idle_q;
    done_d       = done_q;
    err_d        = err_q;
    core_rst_n_d = (state_q == ST_DONE);
    rx_ready     = (state_q == ST_IDLE) || in_frame(state_q);

    if (accept) begin
      idle_d = '0;
    end else if (in_frame(state_q)) begin
      idle_d = idle_q + TO_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (accept && (bus.rx_data == SYNC_BYTE)) begin
          state_d = ST_LEN_HI;
          chk_d   = '0;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_hi_d = bus.rx_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d = len_rx;
          if (len_rx > (LEN_W + 1)'(IMEM_DEPTH)) begin
            state_d = ST_ERR;
          end else if (len_rx == '0) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          chk_d = chk_q ^ bus.rx_data;
          if (frame_last) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (accept) begin
          state_d = (bus.rx_data == chk_q) ? ST_DONE : ST_ERR;
        end
      end
      default: ;
    endcase

    // TIMEOUT consecutive idle cycles inside a frame abort it.
    if (in_frame(state_q) && !accept && (idle_q == TO_W'(TIMEOUT - 1))) begin
      state_d = ST_ERR;
    end

    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      done_d = 1'b1;
    end
    if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_hi_q     <= '0;
      len_q        <= '0;
      chk_q        <= '0;
      idle_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      len_q        <= len_d;
      chk_q        <= chk_d;
      idle_q       <= idle_d;
      done_q       <= done_d;
      err_q        <= err_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign bus.rx_ready = rx_ready;
  assign core_rst_n   = core_rst_n_q;
  assign load_done    = done_q;
  assign load_err     = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int TOUT  = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          core_rst_n;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         wlog[$];
  logic [31:0] wexp[$];

  imem_boot_loader_if #(.ADDR_W(AW)) bus ();

  imem_boot_loader #(
    .IMEM_DEPTH (DEPTH),
    .ADDR_W     (AW),
    .TIMEOUT    (TOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Instruction memory side: every strobe seen mid-cycle is one write.
  always @(negedge clk) begin
    if (!rst && bus.imem_we) wlog.push_back('{addr: bus.imem_addr, data: bus.imem_wdata});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    wlog.delete();
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    idle(2);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] words_xor();
    logic [7:0] acc = 8'h00;
    foreach (wexp[i]) acc ^= wexp[i][31:24] ^ wexp[i][23:16] ^ wexp[i][15:8] ^ wexp[i][7:0];
    return acc;
  endfunction

  task automatic send_frame(input logic [7:0] chk_flip, input int max_gap);
    logic [15:0] n16;
    logic [31:0] w;
    n16 = 16'(wexp.size());
    send_byte(SYNC_BYTE);
    idle($urandom_range(0, max_gap));
    send_byte(n16[15:8]);
    idle($urandom_range(0, max_gap));
    send_byte(n16[7:0]);
    foreach (wexp[i]) begin
      w = wexp[i];
      for (int b = 0; b < 4; b++) begin
        idle($urandom_range(0, max_gap));
        send_byte(w[31 - 8*b -: 8]);
      end
    end
    idle($urandom_range(0, max_gap));
    send_byte(words_xor() ^ chk_flip);
  endtask

  task automatic check_frame(input string tag, input bit exp_done);
    check({tag, "_nwr"}, 64'(wlog.size()), 64'(wexp.size()));
    for (int i = 0; i < wlog.size() && i < wexp.size(); i++) begin
      check({tag, "_addr"}, 64'(wlog[i].addr), 64'(i));
      check({tag, "_data"}, 64'(wlog[i].data), 64'(wexp[i]));
    end
    check({tag, "_wc"}, 64'(word_count), 64'(wexp.size()));
    check({tag, "_done"}, 64'(load_done), 64'(exp_done));
    check({tag, "_err"}, 64'(load_err), 64'(!exp_done));
    check({tag, "_rdy"}, 64'(bus.rx_ready), 64'(0));
    idle(1);
    check({tag, "_crst"}, 64'(core_rst_n), 64'(exp_done));
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    idle(1);
    do_reset();

    check("rst_rdy", 64'(bus.rx_ready), 64'(1));
    check("rst_we", 64'(bus.imem_we), 64'(0));
    check("rst_addr", 64'(bus.imem_addr), 64'(0));
    check("rst_wdata", 64'(bus.imem_wdata), 64'(0));
    check("rst_crst", 64'(core_rst_n), 64'(0));
    check("rst_done", 64'(load_done), 64'(0));
    check("rst_err", 64'(load_err), 64'(0));
    check("rst_wc", 64'(word_count), 64'(0));

    // Two-word frame, back to back, checksum 00.
    wexp = '{32'h12345678, 32'h9ABCDEF0};
    send_frame(8'h00, 0);
    check("f1_crst_lag", 64'(core_rst_n), 64'(0));
    check_frame("f1", 1'b1);

    // Garbage before sync is discarded.
    do_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    wexp = '{$urandom()};
    send_frame(8'h00, 0);
    check_frame("garb", 1'b1);

    // Bad checksum: words are still written, frame rejected.
    do_reset();
    wexp = '{32'h12345678, 32'h9ABCDEF0};
    send_frame(8'h01, 0);
    check_frame("badchk", 1'b0);
    idle(3);
    check("badchk_crst_hold", 64'(core_rst_n), 64'(0));

    // Length one beyond the memory depth.
    do_reset();
    send_byte(SYNC_BYTE);
    send_byte(8'h01);
    send_byte(8'h01);
    check("len_err", 64'(load_err), 64'(1));
    check("len_done", 64'(load_done), 64'(0));
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    idle(2);
    check("len_nwr", 64'(wlog.size()), 64'(0));
    check("len_rdy", 64'(bus.rx_ready), 64'(0));

    // Stall inside a word.
    do_reset();
    send_byte(SYNC_BYTE);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    idle(TOUT - 1);
    check("to_early", 64'(load_err), 64'(0));
    idle(2);
    check("to_err", 64'(load_err), 64'(1));
    check("to_done", 64'(load_done), 64'(0));
    check("to_nwr", 64'(wlog.size()), 64'(0));
    check("to_crst", 64'(core_rst_n), 64'(0));

    // Reset mid-frame after five data bytes, then a clean reload.
    do_reset();
    send_byte(SYNC_BYTE);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    send_byte(8'h9A);
    check("mid_nwr_pre", 64'(wlog.size()), 64'(1));
    do_reset();
    idle(2);
    check("mid_nwr_rst", 64'(wlog.size()), 64'(0));
    check("mid_crst", 64'(core_rst_n), 64'(0));
    wexp = '{32'h12345678, 32'h9ABCDEF0};
    send_frame(8'h00, 0);
    check_frame("mid", 1'b1);

    // Largest legal frame fills the whole memory.
    do_reset();
    wexp.delete();
    for (int i = 0; i < DEPTH; i++) wexp.push_back($urandom());
    send_frame(8'h00, 0);
    check_frame("full", 1'b1);

    // Randomised frames: garbage prefix, length 0..6, gaps, occasional bad checksum.
    for (int it = 0; it < 16; it++) begin
      int          ng;
      int          n;
      logic [7:0]  g;
      logic [7:0]  flip;
      do_reset();
      ng = $urandom_range(0, 3);
      for (int k = 0; k < ng; k++) begin
        g = 8'($urandom_range(0, 255));
        if (g == SYNC_BYTE) g = 8'h00;
        send_byte(g);
        idle($urandom_range(0, 2));
      end
      n = $urandom_range(0, 6);
      wexp.delete();
      for (int i = 0; i < n; i++) wexp.push_back($urandom());
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame(flip, 3);
      check_frame("rnd", flip == 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
